// File: rtl/a_plus_b_arbiter.sv
// Two-port arbitrated adder: picks one requester (round-robin or fixed priority),
// registers a + b with carry and source id, and keeps saturating per-port grant counts.
module a_plus_b_arbiter #(
  parameter int width     = 4,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prio_mode,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [width-1:0]     req0_a,
  input  logic [width-1:0]     req0_b,
  input  logic [width-1:0]     req1_a,
  input  logic [width-1:0]     req1_b,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [width-1:0]     sum_data,
  output logic                 sum_carry,
  output logic                 sum_id,
  output logic [cnt_width-1:0] grant_cnt0,
  output logic [cnt_width-1:0] grant_cnt1
);

  logic             last_grant_reg;
  logic             can_load;
  logic             accept;
  logic             grant_idx;
  logic [1:0]       grant_vec;
  logic [width:0]   sum_next;
  logic [cnt_width-1:0] cnt_vec [2];

  // Grant index is meaningful only when accept is high; ties in round-robin
  // go to the port that did not win last time.
  always_comb begin
    can_load = ~sum_valid | sum_ready;
    accept   = can_load & (req0_valid | req1_valid) & ~rst;
    if (prio_mode)
      grant_idx = ~req0_valid;
    else if (req0_valid && req1_valid)
      grant_idx = ~last_grant_reg;
    else
      grant_idx = ~req0_valid;
    req0_ready = accept & ~grant_idx;
    req1_ready = accept &  grant_idx;
    grant_vec  = {req1_ready, req0_ready};
    if (grant_idx)
      sum_next = {1'b0, req1_a} + {1'b0, req1_b};
    else
      sum_next = {1'b0, req0_a} + {1'b0, req0_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_valid      <= 1'b0;
      sum_data       <= '0;
      sum_carry      <= 1'b0;
      sum_id         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      sum_valid      <= 1'b1;
      sum_data       <= sum_next[width-1:0];
      sum_carry      <= sum_next[width];
      sum_id         <= grant_idx;
      last_grant_reg <= grant_idx;
    end else if (sum_ready) begin
      sum_valid      <= 1'b0;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [cnt_width-1:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg <= '0;
        else if (grant_vec[gi] && (cnt_reg != {cnt_width{1'b1}}))
          cnt_reg <= cnt_reg + cnt_width'(1);
      end
      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign grant_cnt0 = cnt_vec[0];
  assign grant_cnt1 = cnt_vec[1];

endmodule

// File: tb/tb_a_plus_b_arbiter.sv
// Randomised and directed bench for a_plus_b_arbiter against a transaction-level
// model: winner chosen from the arbitration rules, result held in a one-slot buffer.
module tb_a_plus_b_arbiter;
  localparam int W       = 4;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prio_mode = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          sum_valid;
  logic          sum_ready = 1'b0;
  logic [W-1:0]  sum_data;
  logic          sum_carry;
  logic          sum_id;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  a_plus_b_arbiter #(.width(W), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .prio_mode(prio_mode),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_carry(sum_carry), .sum_id(sum_id),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_last;
  bit m_full;
  int m_data, m_carry, m_id;
  int m_cnt [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_full  = 0;
    m_data  = 0;
    m_carry = 0;
    m_id    = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Called at a negedge: drive one cycle of inputs, check ready, advance one edge, check outputs.
  task automatic step(input bit pm, input bit v0, input bit v1,
                      input int a0, input int b0, input int a1, input int b1,
                      input bit sr);
    int win;
    int s;
    bit can_load;
    prio_mode  = pm;
    req0_valid = v0;
    req1_valid = v1;
    req0_a = W'(a0);
    req0_b = W'(b0);
    req1_a = W'(a1);
    req1_b = W'(b1);
    sum_ready = sr;
    #1;
    can_load = !m_full || sr;
    win = -1;
    if (can_load && (v0 || v1)) begin
      if (v0 && v1) win = pm ? 0 : 1 - m_last;
      else          win = v0 ? 0 : 1;
    end
    check_eq("req0_ready", 32'(req0_ready), 32'(win == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(win == 1));
    @(posedge clk);
    if (win >= 0) begin
      s = (win == 0) ? (a0 % (1 << W)) + (b0 % (1 << W)) : (a1 % (1 << W)) + (b1 % (1 << W));
      m_data  = s % (1 << W);
      m_carry = (s >= (1 << W)) ? 1 : 0;
      m_id    = win;
      m_full  = 1;
      m_last  = win;
      if (m_cnt[win] < CNT_MAX) m_cnt[win]++;
    end else if (m_full && sr) begin
      m_full = 0;
    end
    @(negedge clk);
    check_eq("sum_valid", 32'(sum_valid), 32'(m_full));
    if (m_full) begin
      check_eq("sum_data", 32'(sum_data), 32'(m_data));
      check_eq("sum_carry", 32'(sum_carry), 32'(m_carry));
      check_eq("sum_id", 32'(sum_id), 32'(m_id));
    end
    check_eq("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
    check_eq("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
    $display("txn pm=%0d v=%0d%0d sr=%0d win=%0d sum_valid=%0d data=%0h carry=%0d id=%0d cnt=%0d/%0d",
             pm, v0, v1, sr, win, sum_valid, sum_data, sum_carry, sum_id, grant_cnt0, grant_cnt1);
  endtask

  // Assert reset between clock edges and check that it acts without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sum_ready  = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_sum_valid", 32'(sum_valid), 32'd0);
    check_eq("rst_sum_data", 32'(sum_data), 32'd0);
    check_eq("rst_sum_carry", 32'(sum_carry), 32'd0);
    check_eq("rst_sum_id", 32'(sum_id), 32'd0);
    check_eq("rst_cnt0", 32'(grant_cnt0), 32'd0);
    check_eq("rst_cnt1", 32'(grant_cnt1), 32'd0);
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("txn reset");
  endtask

  initial begin
    logic [W-1:0] held;
    model_reset();
    do_reset();

    // Round-robin tie after reset starts at port 0 and alternates
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), 1);
      check_eq("rr_id_seq", 32'(sum_id), 32'(i % 2));
    end

    // Single requester on port 1
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 3, 4, 1);
      check_eq("p1_data", 32'(sum_data), 32'd7);
      check_eq("p1_carry", 32'(sum_carry), 32'd0);
      check_eq("p1_id", 32'(sum_id), 32'd1);
    end

    // Overflow and max-without-overflow
    step(0, 1, 0, 15, 2, 0, 0, 1);
    check_eq("ovf_data", 32'(sum_data), 32'd1);
    check_eq("ovf_carry", 32'(sum_carry), 32'd1);
    step(0, 1, 0, 8, 7, 0, 0, 1);
    check_eq("max_data", 32'(sum_data), 32'hF);
    check_eq("max_carry", 32'(sum_carry), 32'd0);

    // Back-pressure: output held, nothing accepted, then same-cycle reload
    held = sum_data;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), 0);
      check_eq("stall_hold", 32'(sum_data), 32'(held));
    end
    step(0, 1, 1, 1, 1, 2, 2, 1);
    check_eq("stall_release_valid", 32'(sum_valid), 32'd1);

    // Reset with a pending result: it must never appear afterwards
    step(0, 1, 1, 5, 5, 6, 6, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("no_stale", 32'(sum_valid), 32'd0);

    // Fixed priority: port 0 always wins, its counter saturates
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), 1);
      check_eq("prio_id", 32'(sum_id), 32'd0);
    end
    check_eq("prio_cnt0_sat", 32'(grant_cnt0), 32'd7);
    check_eq("prio_cnt1", 32'(grant_cnt1), 32'd0);

    // Random traffic, including mode changes and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15),
           1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a_plus_b_arbiter.md
A_PLUS_B_ARBITER -- requirements
Module: a_plus_b_arbiter

Interface
REQ-001 SHALL have parameter width, default 4, meaning operand and sum width in bits.
REQ-002 SHALL have parameter cnt_width, default 16, meaning width of each per-port grant counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port prio_mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operand pair.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  the pair is accepted this cycle.
REQ-008 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  width each  operands.
REQ-009 SHALL have port sum_valid  output  1  output register holds a result.
REQ-010 SHALL have port sum_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port sum_data  output  width  registered a + b, truncated to width.
REQ-012 SHALL have port sum_carry  output  1  carry out of the width-bit addition.
REQ-013 SHALL have port sum_id  output  1  index of the requester that produced sum_data.
REQ-014 SHALL have ports grant_cnt0 / grant_cnt1  output  cnt_width each  accepted transfers per port.

Function
REQ-015 SHALL count a transfer on a requester port when valid & ready are both 1 at a rising clk edge, and on the output when sum_valid & sum_ready are both 1 at a rising clk edge.
REQ-016 SHALL define can_load = ~sum_valid | sum_ready, so a full output register drained this cycle can be reloaded in the same cycle.
REQ-017 SHALL assert at most one of req0_ready, req1_ready in any cycle, and only when can_load = 1 and that port's valid = 1; ready may depend combinationally on valid, prio_mode, sum_ready and state.
REQ-018 SHALL, with prio_mode = 0 and both valid, grant the port other than last_grant; with one valid, grant that port.
REQ-019 SHALL, with prio_mode = 1, grant port 0 whenever req0_valid = 1, otherwise port 1 if req1_valid = 1.
REQ-020 SHALL update the 1-bit last_grant register to the granted index on every accepted transfer, in both modes.
REQ-021 SHALL, on acceptance, load sum_data = (a + b) mod 2^width, sum_carry = bit width of the (width+1)-bit sum, and sum_id = the granted index, and set sum_valid = 1 on the same edge; latency is 1 cycle.
REQ-022 SHALL clear sum_valid on an output transfer with no simultaneous acceptance.
REQ-023 SHALL hold sum_data, sum_carry and sum_id stable while sum_valid = 1 and sum_ready = 0.
REQ-024 SHALL sustain one result per cycle when sum_ready is held at 1.
REQ-025 SHALL increment grant_cntN on each accepted transfer from port N, saturating at 2^cnt_width - 1 (no wrap).
REQ-026 SHALL take effect on a prio_mode change on the next arbitration decision, with no loss or duplication of data.

Reset
REQ-027 SHALL, while rst = 1 and independent of clk, force sum_valid = 0, sum_data = 0, sum_carry = 0, sum_id = 0, grant_cnt0 = grant_cnt1 = 0, and last_grant = 1, so that port 0 wins the first round-robin tie.
REQ-028 SHALL drive req0_ready = req1_ready = 0 while rst = 1.
REQ-029 SHALL discard a result held in the output register when reset is asserted mid-operation; the result is not delivered afterwards.

Verification
REQ-030 Both valid, prio_mode = 0, sum_ready = 1 after reset -> sum_id sequence 0,1,0,1,... at one result per cycle, first result one cycle after first acceptance.
REQ-031 Only req1_valid, a = 3, b = 4, sum_ready = 1 -> req1_ready = 1 every cycle; sum_data = 7, sum_carry = 0, sum_id = 1 one cycle later.
REQ-032 width = 4, a = F, b = 2 -> sum_data = 1, sum_carry = 1; a = 8, b = 7 -> sum_data = F, sum_carry = 0.
REQ-033 sum_valid = 1, sum_ready = 0 for 10 cycles, both valid -> both ready = 0 and outputs stable; sum_ready rises -> new pair accepted in that same cycle.
REQ-034 prio_mode = 1, both valid for 20 cycles -> sum_id = 0 on all 20 results, grant_cnt1 = 0; cnt_width = 3, 10 grants -> grant_cnt0 = 7.
REQ-035 rst asserted between clk edges while sum_valid = 1 -> sum_valid, counters and ready outputs 0 immediately; after release, a scoreboard shows no stale result.
